// File: rtl/sort_job_arbiter.sv
// Shares one N-entry sort engine between two requesters: round-robin grant,
// load stream, start pulse, bounded wait for completion, then result drain.
module sort_job_arbiter #(
  parameter int N       = 8,
  parameter int W       = 4,
  parameter int TIMEOUT = 255,
  localparam int AW     = (N > 1) ? $clog2(N) : 1,
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req,
  input  logic [1:0]     in_valid,
  input  logic [2*W-1:0] in_data,
  output logic [1:0]     in_ready,
  output logic [1:0]     out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic [1:0]     out_ready,
  output logic [1:0]     grant,
  output logic           err,
  output logic           srt_ld_we,
  output logic [AW-1:0]  srt_ld_addr,
  output logic [W-1:0]   srt_ld_data,
  output logic           srt_start,
  output logic           srt_clr,
  input  logic           srt_done,
  output logic [AW-1:0]  srt_rd_addr,
  input  logic [W-1:0]   srt_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [AW-1:0] CNT_MAX = AW'(N - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          lg_q, lg_d;
  logic          gidx;
  logic          ld_acc;
  logic          rd_acc;
  logic          tmo;

  // gidx is the index of the current owner; only meaningful while grant != 00
  assign gidx   = grant_q[1];
  assign ld_acc = (state_q == S_LOAD)  && in_valid[gidx];
  assign rd_acc = (state_q == S_DRAIN) && out_ready[gidx];
  assign tmo    = (state_q == S_WAIT)  && !srt_done && (timer_q == T_LAST);
  assign grant  = grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      cnt_q   <= '0;
      timer_q <= '0;
      lg_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      lg_q    <= lg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    lg_d    = lg_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // On a tie the requester that did not own the last job wins
          if (&req) grant_d = lg_q ? 2'b01 : 2'b10;
          else      grant_d = req;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_acc) begin
          if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (srt_done) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else if (tmo) begin
          lg_d    = gidx;
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (rd_acc) begin
          if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            lg_d    = gidx;
            grant_d = 2'b00;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready    = 2'b00;
    out_valid   = 2'b00;
    out_data    = '0;
    out_last    = 1'b0;
    err         = 1'b0;
    srt_ld_we   = 1'b0;
    srt_ld_addr = '0;
    srt_ld_data = '0;
    srt_start   = 1'b0;
    srt_clr     = 1'b0;
    srt_rd_addr = '0;
    case (state_q)
      S_LOAD: begin
        in_ready    = grant_q;
        srt_ld_we   = in_valid[gidx];
        srt_ld_addr = cnt_q;
        srt_ld_data = gidx ? in_data[2*W-1:W] : in_data[W-1:0];
      end
      S_START: srt_start = 1'b1;
      S_WAIT: begin
        err     = tmo;
        srt_clr = tmo;
      end
      S_DRAIN: begin
        // Read data follows cnt, which only moves on a handshake, so it holds while stalled
        out_valid   = grant_q;
        srt_rd_addr = cnt_q;
        out_data    = srt_rd_data;
        out_last    = (cnt_q == CNT_MAX);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Directed bench for sort_job_arbiter with a behavioural sort-engine model.
module tb_sort_job_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_t;
  logic [1:0] req;
  logic [1:0] in_valid;
  logic [7:0] in_data;
  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic [1:0] out_ready;
  logic [1:0] grant;
  logic       err;
  logic       srt_ld_we;
  logic [2:0] srt_ld_addr;
  logic [3:0] srt_ld_data;
  logic       srt_start;
  logic       srt_clr;
  logic       srt_done;
  logic [2:0] srt_rd_addr;
  logic [3:0] srt_rd_data;

  // Second instance with a short timeout and an engine that never finishes
  logic [1:0] t_in_ready, t_out_valid, t_grant;
  logic [3:0] t_out_data, t_ld_data;
  logic       t_out_last, t_err, t_ld_we, t_start, t_clr;
  logic [2:0] t_ld_addr, t_rd_addr;
  logic       t_done = 1'b0;
  logic [3:0] t_rd_data = 4'd0;

  int n_chk = 0;
  int n_pass = 0;
  int n_start = 0;
  int n_we = 0;
  logic stray = 1'b0;
  logic [31:0] memv = '0;
  logic [31:0] sorted;
  logic [4:0]  dcnt = '0;
  logic [3:0]  ld_words [8];
  logic [3:0]  exp_out [8];

  always #5 clk = ~clk;

  sort_job_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .grant(grant), .err(err), .srt_ld_we(srt_ld_we),
    .srt_ld_addr(srt_ld_addr), .srt_ld_data(srt_ld_data), .srt_start(srt_start),
    .srt_clr(srt_clr), .srt_done(srt_done), .srt_rd_addr(srt_rd_addr), .srt_rd_data(srt_rd_data)
  );

  sort_job_arbiter #(.TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst_t), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(t_in_ready), .out_valid(t_out_valid), .out_data(t_out_data), .out_last(t_out_last),
    .out_ready(out_ready), .grant(t_grant), .err(t_err), .srt_ld_we(t_ld_we),
    .srt_ld_addr(t_ld_addr), .srt_ld_data(t_ld_data), .srt_start(t_start),
    .srt_clr(t_clr), .srt_done(t_done), .srt_rd_addr(t_rd_addr), .srt_rd_data(t_rd_data)
  );

  function automatic logic [31:0] sort8(input logic [31:0] v);
    logic [3:0] a [8];
    logic [3:0] t;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[i*4 +: 4];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = a[i];
    return r;
  endfunction

  assign sorted      = sort8(memv);
  assign srt_rd_data = sorted[srt_rd_addr*4 +: 4];
  assign srt_done    = (dcnt == 5'd1) | stray;

  // Engine model: finishes 20 cycles after the start pulse
  always @(posedge clk) begin
    if (srt_clr) memv <= '0;
    else if (srt_ld_we) memv[srt_ld_addr*4 +: 4] <= srt_ld_data;
    if (srt_start) dcnt <= 5'd20;
    else if (dcnt != 0) dcnt <= dcnt - 5'd1;
    if (srt_start) n_start <= n_start + 1;
    if (srt_ld_we) n_we <= n_we + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic run_job(input int k, input bit bp, input int drop_at, input int stray_at);
    int i, j, budget, st0, we0;
    bit ph;
    st0 = n_start;
    we0 = n_we;
    budget = 0;
    do begin
      @(negedge clk); #1; budget++;
    end while (grant == 2'b00 && budget < 10);
    check("grant", grant, 32'(1 << k));
    i = 0; ph = 1'b0; budget = 0;
    while (i < 8 && budget < 100) begin
      in_valid = 2'b00;
      in_valid[k] = bp ? ph : 1'b1;
      in_data = '0;
      in_data[k*4 +: 4] = ld_words[i];
      if (i == drop_at) req[k] = 1'b0;
      stray = (i == stray_at) && in_valid[k];
      #1;
      check("ld_we", srt_ld_we, in_valid[k]);
      check("in_ready_other", in_ready[1-k], 0);
      if (in_valid[k]) begin
        check("ld_addr", srt_ld_addr, i);
        check("ld_data", srt_ld_data, ld_words[i]);
        check("in_ready", in_ready[k], 1);
        i++;
      end
      ph = ~ph; budget++;
      @(negedge clk);
    end
    check("load_count", i, 8);
    in_valid = 2'b00;
    stray = 1'b0;
    j = 0; ph = 1'b0; budget = 0;
    while (j < 8 && budget < 200) begin
      out_ready = 2'b00;
      out_ready[k] = bp ? ph : 1'b1;
      #1;
      if (out_valid[k]) begin
        check("out_data", out_data, exp_out[j]);
        check("out_last", out_last, j == 7);
        check("out_valid_other", out_valid[1-k], 0);
        if (out_ready[k]) j++;
      end
      ph = ~ph; budget++;
      @(negedge clk);
    end
    check("drain_count", j, 8);
    out_ready = 2'b00;
    #1;
    check("grant_idle", grant, 0);
    check("start_pulses", n_start - st0, 1);
    check("ld_writes", n_we - we0, 8);
  endtask

  initial begin
    int budget, c;
    bit seen;
    rst = 1'b1; rst_t = 1'b1;
    req = 2'b00; in_valid = 2'b00; in_data = '0; out_ready = 2'b00;
    #1;
    check("rst_grant", grant, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_start", srt_start, 0);
    check("rst_ld_we", srt_ld_we, 0);
    check("rst_t_grant", t_grant, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single job from requester 0
    ld_words = '{4'd8, 4'd1, 4'd8, 4'd1, 4'd8, 4'd1, 4'd8, 4'd1};
    exp_out  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd8, 4'd8, 4'd8, 4'd8};
    req = 2'b01;
    run_job(0, 1'b0, -1, -1);
    req = 2'b00;

    // Tie after reset, then round-robin hand-over with backpressure
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    req = 2'b11;
    run_job(0, 1'b0, -1, -1);
    @(negedge clk); #1;
    check("rr_grant", grant, 2'b10);
    ld_words = '{4'd5, 4'd3, 4'd9, 4'd0, 4'd7, 4'd2, 4'd6, 4'd4};
    exp_out  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    run_job(1, 1'b1, -1, -1);
    req = 2'b00;

    // Asynchronous reset in the middle of a load
    @(negedge clk);
    req = 2'b01;
    budget = 0;
    do begin
      @(negedge clk); #1; budget++;
    end while (grant == 2'b00 && budget < 10);
    for (int i = 0; i < 3; i++) begin
      in_valid = 2'b01; in_data = 8'(i + 3);
      @(negedge clk);
    end
    #1;
    check("pre_rst_addr", srt_ld_addr, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_ld_we", srt_ld_we, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 2'b00;
    ld_words = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    exp_out  = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    run_job(0, 1'b0, -1, -1);

    // Stray done during load and request dropped mid-job
    ld_words = '{4'd2, 4'd7, 4'd1, 4'd7, 4'd3, 4'd0, 4'd5, 4'd5};
    exp_out  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd5, 4'd7, 4'd7};
    run_job(0, 1'b0, 2, 4);
    req = 2'b00;

    // Timeout on the short-timeout instance
    @(negedge clk);
    rst = 1'b1; rst_t = 1'b0;
    req = 2'b11; in_valid = 2'b11; in_data = 8'h5A;
    budget = 0;
    do begin
      @(negedge clk); #1; budget++;
    end while (!t_start && budget < 40);
    check("to_start", t_start, 1);
    check("to_owner", t_grant, 2'b01);
    in_valid = 2'b00;
    c = 0; seen = 1'b0;
    do begin
      @(negedge clk); #1; c++;
      if (|t_out_valid) seen = 1'b1;
    end while (!t_err && c < 40);
    check("to_err_delay", c, 16);
    check("to_clr", t_clr, 1);
    check("to_no_out", seen, 0);
    @(negedge clk); #1;
    check("to_idle_grant", t_grant, 0);
    check("to_err_pulse", t_err, 0);
    @(negedge clk); #1;
    check("to_next_grant", t_grant, 2'b10);
    req = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
